// File: rtl/qspi_tx_shifter.sv
// ============================================================================
// qspi_tx_shifter -- QSPI transmit shifter: pulls 32-bit words from a TX FIFO
// and drives them MSB-first on 1/2/4 lanes. Optional macro QSPI_TX_PREFETCH_EN
// enables gapless word-to-word prefetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qspi_tx_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  word_count,
    input  logic [1:0]  lane_mode,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    input  logic [31:0] fifo_data,
    output logic [3:0]  io_out,
    output logic [3:0]  io_oe,
    output logic        sclk_en,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] M_SINGLE = 2'd0;
    localparam logic [1:0] M_DUAL   = 2'd1;
    localparam logic [1:0] M_QUAD   = 2'd2;

    state_t      state_q;
    logic [1:0]  mode_q;
    logic [7:0]  words_q;
    logic [31:0] sr_q;
    logic [5:0]  grp_q;
    logic        pf_q;
    logic [3:0]  io_out_q;
    logic [3:0]  io_oe_q;
    logic        sclk_en_q;
    logic        busy_q;
    logic        done_q;

    logic [1:0]  mode_d;
    logic        last_grp_d;
    logic        more_words_d;
    logic        pf_rd_d;

    function automatic logic [3:0] grp_of(input logic [31:0] d, input logic [1:0] m);
        case (m)
            M_SINGLE: grp_of = {3'b000, d[31]};
            M_DUAL:   grp_of = {2'b00, d[31:30]};
            default:  grp_of = d[31:28];
        endcase
    endfunction

    function automatic logic [31:0] shl(input logic [31:0] d, input logic [1:0] m);
        case (m)
            M_SINGLE: shl = {d[30:0], 1'b0};
            M_DUAL:   shl = {d[29:0], 2'b00};
            default:  shl = {d[27:0], 4'b0000};
        endcase
    endfunction

    function automatic logic [5:0] ngroups(input logic [1:0] m);
        case (m)
            M_SINGLE: ngroups = 6'd32;
            M_DUAL:   ngroups = 6'd16;
            default:  ngroups = 6'd8;
        endcase
    endfunction

    function automatic logic [3:0] oe_of(input logic [1:0] m);
        case (m)
            M_SINGLE: oe_of = 4'b0001;
            M_DUAL:   oe_of = 4'b0011;
            default:  oe_of = 4'b1111;
        endcase
    endfunction

    // Mode 11 collapses onto quad so the datapath only sees three encodings.
    assign mode_d = (lane_mode == 2'b00) ? M_SINGLE :
                    (lane_mode == 2'b01) ? M_DUAL : M_QUAD;

    assign last_grp_d   = (grp_q == 6'd1);
    assign more_words_d = (words_q > 8'd1);

`ifdef QSPI_TX_PREFETCH_EN
    assign pf_rd_d = (state_q == S_SHIFT) && (grp_q == 6'd2) && more_words_d && !fifo_empty;
`else
    assign pf_rd_d = 1'b0;
`endif

    // Read strobe is gated by the live empty flag so it can never fire on an empty FIFO.
    assign fifo_rd_en = ((state_q == S_FETCH) && !fifo_empty) || pf_rd_d;

    assign io_out  = io_out_q;
    assign io_oe   = io_oe_q;
    assign sclk_en = sclk_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= M_SINGLE;
            words_q   <= 8'd0;
            sr_q      <= 32'd0;
            grp_q     <= 6'd0;
            pf_q      <= 1'b0;
            io_out_q  <= 4'd0;
            io_oe_q   <= 4'd0;
            sclk_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pf_q   <= pf_rd_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode_d;
                        words_q <= word_count;
                        busy_q  <= 1'b1;
                        io_oe_q <= oe_of(mode_d);
                        if (word_count == 8'd0) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sr_q      <= shl(fifo_data, mode_q);
                    io_out_q  <= grp_of(fifo_data, mode_q);
                    grp_q     <= ngroups(mode_q);
                    sclk_en_q <= 1'b1;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!last_grp_d) begin
                        io_out_q <= grp_of(sr_q, mode_q);
                        sr_q     <= shl(sr_q, mode_q);
                        grp_q    <= grp_q - 6'd1;
                    end else begin
                        words_q <= words_q - 8'd1;
                        if (!more_words_d) begin
                            state_q   <= S_FINISH;
                            done_q    <= 1'b1;
                            sclk_en_q <= 1'b0;
                            io_out_q  <= 4'd0;
                        end else if (pf_q) begin
                            // Prefetched word is on fifo_data now: continue without a gap.
                            sr_q     <= shl(fifo_data, mode_q);
                            io_out_q <= grp_of(fifo_data, mode_q);
                            grp_q    <= ngroups(mode_q);
                        end else begin
                            state_q   <= S_FETCH;
                            sclk_en_q <= 1'b0;
                            io_out_q  <= 4'd0;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    io_oe_q <= 4'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/qspi_tx_shifter.md
QSPI_TX_SHIFTER -- requirements
Module: qspi_tx_shifter

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL provide: rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL provide: start  in  1  one-cycle pulse launching a transfer.
REQ-004 SHALL provide: word_count  in  8  number of 32-bit words to send.
REQ-005 SHALL provide: lane_mode  in  2  00 single, 01 dual, 10 quad, 11 treated as quad.
REQ-006 SHALL provide: fifo_empty  in  1  TX FIFO empty flag.
REQ-007 SHALL provide: fifo_rd_en  out  1  TX FIFO read strobe.
REQ-008 SHALL provide: fifo_data  in  32  TX FIFO registered output, valid the cycle after fifo_rd_en.
REQ-009 SHALL provide: io_out  out  4  serial data to IO3..IO0.
REQ-010 SHALL provide: io_oe  out  4  per-lane output enable.
REQ-011 SHALL provide: sclk_en  out  1  high in each cycle a bit-group is driven.
REQ-012 SHALL provide: busy  out  1  transfer in progress.
REQ-013 SHALL provide: done  out  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, LOAD, SHIFT, FINISH.
REQ-015 IDLE: start sampled with busy low; word_count and lane_mode latched; word_count=0 -> FINISH, else FETCH; start while busy SHALL be ignored.
REQ-016 FETCH: assert fifo_rd_en for exactly one cycle when fifo_empty low, then LOAD; while fifo_empty high, SHALL hold in FETCH with rd_en and sclk_en low (stall, no error).
REQ-017 LOAD: capture fifo_data into the 32-bit shift register; group counter = 32/16/8 for single/dual/quad; go to SHIFT.
REQ-018 SHIFT: every cycle sclk_en=1, drive MSB-first group: single io_out[0]=bit31; dual io_out[1:0]=bits31:30; quad io_out[3:0]=bits31:28; unused io_out bits 0; shift left by 1/2/4.
REQ-019 io_oe SHALL be 0001/0011/1111 by latched mode while busy, 0000 otherwise.
REQ-020 After the last group of a word: words remain -> FETCH, else FINISH.
REQ-021 FINISH: done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
REQ-022 busy SHALL be high from the cycle after an accepted start through the FINISH cycle.
REQ-023 fifo_rd_en SHALL never be asserted while fifo_empty is high, nor more than word_count times per transfer.

Reset
REQ-024 rst_n low at a clock edge SHALL force IDLE and fifo_rd_en, io_out, io_oe, sclk_en, busy, done to 0, including mid-transfer; partially shifted data discarded.
REQ-025 No pending start SHALL be remembered across reset.

Configuration
REQ-026 Macro QSPI_TX_PREFETCH_EN SHALL select gapless prefetch.
REQ-027 Defined: in SHIFT with 2 groups remaining, words remaining >1 and fifo_empty low, assert fifo_rd_en; load fifo_data at the final group edge; next word's first group follows in the next cycle (no sclk_en gap); if empty at that point, fall back to FETCH.
REQ-028 Undefined: no prefetch; each word boundary inserts exactly 2 cycles (FETCH, LOAD) with sclk_en low.

Verification
REQ-029 Quad, word_count=1, FIFO holds 0xA5C31E7F -> io_out A,5,C,3,1,E,7,F on 8 consecutive sclk_en cycles, io_oe=1111, done pulses next cycle, one rd_en total.
REQ-030 Single, word 0x80000001 -> io_out[0]=1, 30 zeros, then 1 over 32 sclk_en cycles, io_out[3:1]=0, io_oe=0001.
REQ-031 Dual, words 0x12345678, 0x9ABCDEF0 preloaded -> 32 sclk_en cycles; with QSPI_TX_PREFETCH_EN contiguous; without, 16 + 2 idle + 16.
REQ-032 Quad, word_count=2, one word present -> after 8 groups sclk_en low, no rd_en while empty; write 0xDEADBEEF 10 cycles later -> D,E,A,D,B,E,E,F shifted, then done.
REQ-033 word_count=0 -> done one cycle after FINISH entry, no rd_en, no sclk_en.
REQ-034 rst_n low during quad group 4 -> next cycle all outputs 0; a start pulsed while busy produces no second transfer.
